// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer: round-robin scan controller for a 4-bit SAR converter.
// Each scan picks the next enabled mux channel, waits a fixed settle time,
// holds sar_run high until sar_done, then offers a channel-tagged result.
//
// Handshake: a result transfers on a rising edge where o_res_valid and
// i_res_ready are both high; o_res_valid/o_res_data/o_res_ch stay stable
// until that edge, and i_res_ready is ignored while o_res_valid is low.
//
// Optional feature macro: SARSEQ_TIMEOUT_EN. When defined, a conversion that
// sees no sar_done within TIMEOUT CONV cycles is abandoned and o_err is set
// (sticky until reset). When undefined, CONV waits forever and o_err is 0.
module sar_scan_sequencer #(
    parameter int NCH     = 4,
    parameter int RES_W   = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 64,
    localparam int CW     = $clog2(NCH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [NCH-1:0]   i_ch_mask,
    output logic [CW-1:0]    o_mux_sel,
    output logic             o_sar_run,
    input  logic [RES_W-1:0] i_sar_bitout,
    input  logic             i_sar_done,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [RES_W-1:0] o_res_data,
    output logic [CW-1:0]    o_res_ch,
    output logic             o_busy,
    output logic             o_err,
    output logic [1:0]       o_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CONV   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    // One counter serves both the settle countdown and the CONV timeout.
    localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_ptr;
    logic [CW-1:0]    r_mux_sel;
    logic             r_sar_run;
    logic             r_res_valid;
    logic [RES_W-1:0] r_res_data;
    logic [CW-1:0]    r_res_ch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;

    logic [CW-1:0]    w_sel_hi;
    logic [CW-1:0]    w_sel_lo;
    logic             w_hi_found;
    logic [CW-1:0]    w_sel;
    logic [CW-1:0]    w_ptr_next;

    // Channel pick: lowest set mask bit at or above ptr, else lowest set bit overall.
    always_comb begin
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        w_hi_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_ch_mask[i]) begin
                w_sel_lo = CW'(i);
                if (i >= int'(r_ptr)) begin
                    w_sel_hi   = CW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_sel = w_hi_found ? w_sel_hi : w_sel_lo;
    end

    // Pointer moves one past the channel just served, wrapping at NCH.
    assign w_ptr_next = (r_mux_sel == CW'(NCH - 1)) ? '0 : r_mux_sel + CW'(1);

`ifdef SARSEQ_TIMEOUT_EN
    logic r_err;
`endif

    // Scan FSM and all registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_mux_sel   <= '0;
            r_sar_run   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ch    <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b0;
`ifdef SARSEQ_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable && (i_ch_mask != '0)) begin
                        r_mux_sel <= w_sel;
                        r_cnt     <= CNT_W'(SETTLE - 1);
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_sar_run <= 1'b1;
                        r_first   <= 1'b1;
`ifdef SARSEQ_TIMEOUT_EN
                        r_cnt     <= CNT_W'(TIMEOUT - 1);
`endif
                        r_state   <= S_CONV;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_CONV: begin
                    // The first CONV cycle ignores sar_done so a stale done
                    // from the previous conversion cannot end this one.
                    r_first <= 1'b0;
                    if (!r_first && i_sar_done) begin
                        r_res_data  <= i_sar_bitout;
                        r_res_ch    <= r_mux_sel;
                        r_res_valid <= 1'b1;
                        r_sar_run   <= 1'b0;
                        r_state     <= S_HOLD;
                    end
`ifdef SARSEQ_TIMEOUT_EN
                    else if (r_cnt == '0) begin
                        r_sar_run <= 1'b0;
                        r_err     <= 1'b1;
                        r_ptr     <= w_ptr_next;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SARSEQ_TIMEOUT_EN
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_mux_sel   = r_mux_sel;
    assign o_sar_run   = r_sar_run;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_ch    = r_res_ch;
    assign o_busy      = (r_state != S_IDLE);
    assign o_state     = r_state;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Bench for sar_scan_sequencer: SAR model answering ch+3 after a fixed delay,
// a result scoreboard, and one task per scenario.
module tb_sar_scan_sequencer;

  localparam int NCH      = 4;
  localparam int RES_W    = 4;
  localparam int SETTLE   = 3;
  localparam int TIMEOUT  = 64;
  localparam int CW       = 2;
  localparam int DONE_LAT = 5;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [NCH-1:0]   ch_mask;
  logic [CW-1:0]    mux_sel;
  logic             sar_run;
  logic [RES_W-1:0] sar_bitout;
  logic             sar_done;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic [CW-1:0]    res_ch;
  logic             busy;
  logic             err;
  logic [1:0]       state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW+RES_W-1:0] exp_q[$];

  logic force_done;
  logic stuck_low;
  int   sar_cnt;

  sar_scan_sequencer #(
    .NCH(NCH), .RES_W(RES_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_ch_mask(ch_mask),
    .o_mux_sel(mux_sel), .o_sar_run(sar_run), .i_sar_bitout(sar_bitout),
    .i_sar_done(sar_done), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_ch(res_ch), .o_busy(busy), .o_err(err),
    .o_state(state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SAR model: done DONE_LAT cycles after run rises, result = channel + 3
  always @(posedge clk or posedge reset) begin
    if (reset) sar_cnt <= 0;
    else if (!sar_run) sar_cnt <= 0;
    else sar_cnt <= sar_cnt + 1;
  end
  assign sar_done   = force_done | (!stuck_low && sar_run && (sar_cnt >= DONE_LAT));
  assign sar_bitout = RES_W'(int'(mux_sel) + 3);

  function automatic logic [CW+RES_W-1:0] exp_item(input int ch);
    exp_item = {CW'(ch), RES_W'(ch + 3)};
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  logic          prev_busy = 1'b0;
  logic [CW-1:0] prev_mux  = '0;
  always @(negedge clk) begin
    logic [CW+RES_W-1:0] exp;
    if (!reset) begin
      if (busy && prev_busy) begin
        n_tests++;
        if (mux_sel !== prev_mux) begin
          n_fail++;
          $display("FAIL mux_stable: mux_sel=%0d required %0d", mux_sel, prev_mux);
        end
      end
      if (res_valid && res_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: ch=%0d data=%0d required no result", res_ch, res_data);
        end else begin
          exp = exp_q.pop_front();
          if ({res_ch, res_data} !== exp) begin
            n_fail++;
            $display("FAIL result: ch=%0d data=%0d required ch=%0d data=%0d",
                     res_ch, res_data, exp[CW+RES_W-1:RES_W], exp[RES_W-1:0]);
          end
        end
      end
    end
    prev_busy = busy;
    prev_mux  = mux_sel;
  end

  // driver tasks
  function automatic logic cond(input int which);
    case (which)
      0: cond = busy;
      1: cond = !busy;
      2: cond = res_valid;
      3: cond = sar_run;
      4: cond = (state == S_SETTLE);
      default: cond = (exp_q.size() == 0);
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string name);
    int n = 0;
    while (!cond(which) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (!cond(which)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: condition not met after %0d cycles, required within %0d", name, n, budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; res_ready = 1'b1; ch_mask = '0;
    force_done = 1'b0; stuck_low = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Waits until all expected results are consumed, stops scanning, checks idle.
  task automatic finish_scan(input string name);
    wait_for(5, 2000, {name, "_drain"});
    enable = 1'b0;
    wait_for(1, 300, {name, "_idle"});
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if ({busy, res_valid, state} !== {1'b0, 1'b0, S_IDLE}) begin
      n_fail++;
      $display("FAIL %s_stopped: busy=%0b valid=%0b state=%0d required 0 0 %0d",
               name, busy, res_valid, state, S_IDLE);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d results outstanding required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; ch_mask = 4'hF; res_ready = 1'b1;
    force_done = 1'b0; stuck_low = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_tests++;
    if ({sar_run, res_valid, busy, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: run=%0b valid=%0b busy=%0b err=%0b required 0000",
               sar_run, res_valid, busy, err);
    end
    n_tests++;
    if ({mux_sel, res_data, res_ch, state} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: mux=%0d data=%0d ch=%0d state=%0d required 0",
               mux_sel, res_data, res_ch, state);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int lat;
    do_reset();
    ch_mask = 4'b1111;
    exp_q.push_back(exp_item(0)); exp_q.push_back(exp_item(1));
    exp_q.push_back(exp_item(2)); exp_q.push_back(exp_item(3));
    exp_q.push_back(exp_item(0));
    enable = 1'b1;
    wait_for(0, 20, "rr_start");
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != SETTLE + DONE_LAT + 1) begin
      n_fail++;
      $display("FAIL rr_latency: %0d cycles required %0d", lat, SETTLE + DONE_LAT + 1);
    end
    finish_scan("rr");
  endtask

  task automatic test_mask_pattern();
    do_reset();
    ch_mask = 4'b1010;
    exp_q.push_back(exp_item(1)); exp_q.push_back(exp_item(3));
    exp_q.push_back(exp_item(1)); exp_q.push_back(exp_item(3));
    enable = 1'b1;
    finish_scan("mask1010");
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_mask = 4'b1111;
    res_ready = 1'b0;
    exp_q.push_back(exp_item(0)); exp_q.push_back(exp_item(1));
    enable = 1'b1;
    wait_for(2, 100, "bp_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({res_valid, res_ch, res_data, sar_run, state} !==
          {1'b1, CW'(0), RES_W'(3), 1'b0, S_HOLD}) begin
        n_fail++;
        $display("FAIL bp_hold: valid=%0b ch=%0d data=%0d run=%0b state=%0d required 1 0 3 0 %0d",
                 res_valid, res_ch, res_data, sar_run, state, S_HOLD);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    finish_scan("bp");
  endtask

  task automatic test_enable_drop();
    do_reset();
    ch_mask = 4'b1111;
    exp_q.push_back(exp_item(0));
    enable = 1'b1;
    wait_for(4, 20, "drop_settle");
    enable = 1'b0;
    wait_for(1, 100, "drop_idle");
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if ({busy, exp_q.size() == 0} !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_one_result: busy=%0b outstanding=%0d required busy=0 outstanding=0",
               busy, exp_q.size());
    end
  endtask

  task automatic test_stale_done();
    int lat;
    do_reset();
    ch_mask = 4'b0100;
    force_done = 1'b1;
    exp_q.push_back(exp_item(2)); exp_q.push_back(exp_item(2));
    enable = 1'b1;
    wait_for(0, 20, "stale_start");
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != SETTLE + 2) begin
      n_fail++;
      $display("FAIL stale_latency: %0d cycles required %0d", lat, SETTLE + 2);
    end
    finish_scan("single_ch");
    force_done = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    do_reset();
    ch_mask = 4'b1111;
    exp_q.push_back(exp_item(0));
    enable = 1'b1;
    wait_for(5, 200, "mid_first");
    wait_for(3, 50, "mid_conv");
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({sar_run, res_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: run=%0b valid=%0b busy=%0b required 000", sar_run, res_valid, busy);
    end
    @(negedge clk); @(negedge clk);
    exp_q.push_back(exp_item(0));
    reset = 1'b0;
    finish_scan("restart");
  endtask

`ifdef SARSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    ch_mask = 4'b0011;
    stuck_low = 1'b1;
    enable = 1'b1;
    wait_for(3, 50, "tmo_run");
    n = 0;
    while (sar_run && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    n_tests++;
    if (n != TIMEOUT) begin
      n_fail++;
      $display("FAIL tmo_length: run high %0d cycles required %0d", n, TIMEOUT);
    end
    n_tests++;
    if ({err, res_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL tmo_err: err=%0b valid=%0b required 1 0", err, res_valid);
    end
    wait_for(0, 20, "tmo_next");
    n_tests++;
    if (mux_sel !== CW'(1)) begin
      n_fail++;
      $display("FAIL tmo_next_ch: mux_sel=%0d required 1", mux_sel);
    end
    enable = 1'b0;
    wait_for(1, 300, "tmo_idle");
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: err=%0b required 1", err);
    end
    stuck_low = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; ch_mask = '0; res_ready = 1'b1;
    force_done = 1'b0; stuck_low = 1'b0;
    test_reset();
    test_round_robin();
    test_mask_pattern();
    test_backpressure();
    test_enable_drop();
    test_stale_done();
    test_reset_mid_conv();
`ifdef SARSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
